// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - RV integer execute unit: single-cycle base ALU plus iterative M-extension mul/div
module exec_unit #(
    parameter int XLEN   = 32,
    parameter int MUL_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic            alu_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int SW = $clog2(XLEN);
    localparam logic [SW-1:0] LAST = SW'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic            accept;
    logic            is_mop;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] base_res;

    // M-op working registers: {hi,lo} is the product accumulator or the
    // remainder/quotient pair; mcand holds the multiplicand or divisor magnitude
    logic [2:0]      op;
    logic            neg;
    logic [SW-1:0]   cnt;
    logic [XLEN-1:0] hi, lo, mcand;

    logic            a_sgn, b_sgn;
    logic [XLEN-1:0] a_mag, b_mag;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_sh;
    logic [XLEN+1:0]   div_diff;
    logic [XLEN-1:0]   hi_n, lo_n;
    logic [2*XLEN-1:0] prod, prod_c;
    logic [XLEN-1:0]   m_res;

    assign accept    = in_valid && in_ready;
    assign is_mop    = (MUL_EN != 0) && alu_op && (func7 == 7'b0000001);
    assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
    assign out_valid = (state == DONE);
    assign busy      = (state == CALC);
    assign shamt     = b[SW-1:0];

    // Single-cycle base ALU evaluated on the live inputs at the accept edge
    always_comb begin
        base_res = a + b;
        if (alu_op) begin
            case (func3)
                3'b000:  base_res = (func7 != 7'd0) ? (a - b) : (a + b);
                3'b001:  base_res = a << shamt;
                3'b010:  base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
                3'b011:  base_res = {{(XLEN-1){1'b0}}, (a < b)};
                3'b100:  base_res = a ^ b;
                3'b101:  base_res = (func7 != 7'd0) ? $unsigned($signed(a) >>> shamt) : (a >> shamt);
                3'b110:  base_res = a | b;
                default: base_res = a & b;
            endcase
        end
    end

    // Operand signedness per M op; the iterative core only works on magnitudes
    always_comb begin
        a_sgn = ((func3 == 3'b001) || (func3 == 3'b010) || (func3 == 3'b100) || (func3 == 3'b110))
                && a[XLEN-1];
        b_sgn = ((func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110)) && b[XLEN-1];
        a_mag = a_sgn ? (~a + 1'b1) : a;
        b_mag = b_sgn ? (~b + 1'b1) : b;
    end

    // One iteration: right-shifting shift-add multiply or restoring divide,
    // plus sign fix-up of the final value so the last step can load result directly
    always_comb begin
        mul_sum  = {1'b0, hi} + {1'b0, (lo[0] ? mcand : {XLEN{1'b0}})};
        div_sh   = {hi, lo[XLEN-1]};
        div_diff = {1'b0, div_sh} - {2'b00, mcand};
        if (!op[2]) begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo[XLEN-1:1]};
        end else if (!div_diff[XLEN+1]) begin
            hi_n = div_diff[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], 1'b1};
        end else begin
            hi_n = div_sh[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], 1'b0};
        end
        prod   = {hi_n, lo_n};
        prod_c = neg ? (~prod + 1'b1) : prod;
        case (op)
            3'b000:         m_res = prod_c[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:         m_res = prod_c[2*XLEN-1:XLEN];
            3'b100, 3'b101: m_res = neg ? (~lo_n + 1'b1) : lo_n;
            default:        m_res = neg ? (~hi_n + 1'b1) : hi_n;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state: new op starts from IDLE or from DONE on a same-edge handoff
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = is_mop ? CALC : DONE;
            CALC: if (cnt == LAST) state_next = DONE;
            DONE: begin
                if (accept)         state_next = is_mop ? CALC : DONE;
                else if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture on accept, iterate in CALC, load result on completion
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            op     <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            mcand  <= '0;
        end else if (accept) begin
            cnt <= '0;
            op  <= func3;
            hi  <= '0;
            if (!is_mop) begin
                result <= base_res;
            end else if (!func3[2]) begin
                lo    <= b_mag;
                mcand <= a_mag;
                neg   <= a_sgn ^ b_sgn;
            end else begin
                lo    <= a_mag;
                mcand <= b_mag;
                // Divide by zero keeps the all-ones quotient; remainder sign follows dividend
                neg   <= func3[1] ? a_sgn : ((a_sgn ^ b_sgn) && (b != '0));
            end
        end else if (state == CALC) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) result <= m_res;
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - table-driven bench for exec_unit
module tb_exec_unit;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, in_valid, in_valid_b, out_ready, alu_op;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [XLEN-1:0] a, b;
    logic            in_ready, out_valid, busy;
    logic [XLEN-1:0] result;
    logic            in_ready_b, out_valid_b, busy_b;
    logic [XLEN-1:0] result_b;

    exec_unit #(.XLEN(XLEN), .MUL_EN(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .func3(func3), .func7(func7), .alu_op(alu_op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    exec_unit #(.XLEN(XLEN), .MUL_EN(0)) u_dut_base (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .func3(func3), .func7(func7), .alu_op(alu_op), .a(a), .b(b),
        .out_valid(out_valid_b), .out_ready(1'b1), .result(result_b), .busy(busy_b)
    );

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic        alu;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic alu, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] va, input logic [31:0] vb,
                                input logic [31:0] exp, input int lat);
        mk.alu = alu; mk.f3 = f3; mk.f7 = f7; mk.va = va; mk.vb = vb; mk.exp = exp; mk.lat = lat;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_result(output logic [31:0] res, output int lat, output int busy_cycles);
        lat = 0;
        busy_cycles = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) busy_cycles++;
        end while (!out_valid && lat < 100);
        res = result;
    endtask

    task automatic run_op(input logic alu, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] va, input logic [31:0] vb,
                          output logic [31:0] res, output int lat, output int busy_cycles);
        @(negedge clk);
        alu_op = alu; func3 = f3; func7 = f7; a = va; b = vb;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~va; b = ~vb; func3 = ~f3; func7 = ~f7; alu_op = ~alu;
        wait_result(res, lat, busy_cycles);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] res;
        int lat, bc, stray;

        vq.push_back(mk(1'b0, 3'd0, 7'h00, 32'd5,        32'd7,        32'h0000000C, 1));
        vq.push_back(mk(1'b0, 3'd7, 7'h20, 32'd5,        32'd7,        32'h0000000C, 1));
        vq.push_back(mk(1'b1, 3'd0, 7'h20, 32'd3,        32'd5,        32'hFFFFFFFE, 1));
        vq.push_back(mk(1'b1, 3'd1, 7'h00, 32'd1,        32'h24,       32'h00000010, 1));
        vq.push_back(mk(1'b1, 3'd2, 7'h00, 32'hFFFFFFFF, 32'd1,        32'h00000001, 1));
        vq.push_back(mk(1'b1, 3'd2, 7'h00, 32'd1,        32'hFFFFFFFF, 32'h00000000, 1));
        vq.push_back(mk(1'b1, 3'd3, 7'h00, 32'd1,        32'hFFFFFFFF, 32'h00000001, 1));
        vq.push_back(mk(1'b1, 3'd3, 7'h00, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1));
        vq.push_back(mk(1'b1, 3'd4, 7'h00, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1));
        vq.push_back(mk(1'b1, 3'd5, 7'h00, 32'h80000000, 32'd4,        32'h08000000, 1));
        vq.push_back(mk(1'b1, 3'd5, 7'h20, 32'h80000000, 32'd4,        32'hF8000000, 1));
        vq.push_back(mk(1'b1, 3'd6, 7'h00, 32'h0000000F, 32'h000000F0, 32'h000000FF, 1));
        vq.push_back(mk(1'b1, 3'd7, 7'h00, 32'h0000003C, 32'h0000000F, 32'h0000000C, 1));
        vq.push_back(mk(1'b1, 3'd0, 7'h01, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 33));
        vq.push_back(mk(1'b1, 3'd0, 7'h01, 32'd12345,    32'd1000,     32'h00BC5EA8, 33));
        vq.push_back(mk(1'b1, 3'd1, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33));
        vq.push_back(mk(1'b1, 3'd2, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33));
        vq.push_back(mk(1'b1, 3'd3, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33));
        vq.push_back(mk(1'b1, 3'd4, 7'h01, 32'd17,       32'd0,        32'hFFFFFFFF, 33));
        vq.push_back(mk(1'b1, 3'd6, 7'h01, 32'd17,       32'd0,        32'd17,       33));
        vq.push_back(mk(1'b1, 3'd4, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33));
        vq.push_back(mk(1'b1, 3'd6, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33));
        vq.push_back(mk(1'b1, 3'd4, 7'h01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33));
        vq.push_back(mk(1'b1, 3'd6, 7'h01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33));
        vq.push_back(mk(1'b1, 3'd6, 7'h01, 32'd7,        32'hFFFFFFFE, 32'h00000001, 33));
        vq.push_back(mk(1'b1, 3'd5, 7'h01, 32'd100,      32'd7,        32'd14,       33));
        vq.push_back(mk(1'b1, 3'd7, 7'h01, 32'd100,      32'd7,        32'd2,        33));
        vq.push_back(mk(1'b1, 3'd5, 7'h01, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 33));
        vq.push_back(mk(1'b1, 3'd7, 7'h01, 32'd5,        32'd0,        32'd5,        33));

        rst = 1'b1; in_valid = 1'b0; in_valid_b = 1'b0; out_ready = 1'b1;
        alu_op = 1'b0; func3 = 3'd0; func7 = 7'd0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("in_ready_in_reset", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_result", result, 32'd0);
        check("reset_in_ready", in_ready, 1'b1);

        for (int i = 0; i < vq.size(); i++) begin
            run_op(vq[i].alu, vq[i].f3, vq[i].f7, vq[i].va, vq[i].vb, res, lat, bc);
            check($sformatf("vec%0d_result", i), res, vq[i].exp);
            check($sformatf("vec%0d_latency", i), lat, vq[i].lat);
            check($sformatf("vec%0d_busy_cycles", i), bc, (vq[i].lat > 1) ? vq[i].lat - 1 : 0);
        end

        // Base-only build: func7=0000001 decodes as SUB / SRA
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            alu_op = 1'b1; func7 = 7'h01;
            func3 = (k == 0) ? 3'd0 : 3'd5;
            a = (k == 0) ? 32'd3 : 32'h80000000;
            b = (k == 0) ? 32'd5 : 32'd4;
            in_valid_b = 1'b1;
            @(posedge clk);
            #1 in_valid_b = 1'b0;
            @(negedge clk);
            check($sformatf("base_only%0d_valid", k), out_valid_b, 1'b1);
            check($sformatf("base_only%0d_result", k), result_b, (k == 0) ? 32'hFFFFFFFE : 32'hF8000000);
        end

        // Backpressure in DONE, then back-to-back handoff of base, base, M ops
        @(negedge clk);
        alu_op = 1'b0; func3 = 3'd0; func7 = 7'd0; a = 32'd1; b = 32'd2;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0; a = 32'd55;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d_valid", k), out_valid, 1'b1);
            check($sformatf("stall%0d_result", k), result, 32'd3);
            check($sformatf("stall%0d_in_ready", k), in_ready, 1'b0);
        end
        a = 32'd10; b = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
        #1 check("handoff_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 a = 32'd100; b = 32'd1;
        @(negedge clk);
        check("b2b0_valid", out_valid, 1'b1);
        check("b2b0_result", result, 32'd30);
        @(posedge clk);
        #1 alu_op = 1'b1; func3 = 3'd0; func7 = 7'h01; a = 32'd6; b = 32'd7;
        @(negedge clk);
        check("b2b1_valid", out_valid, 1'b1);
        check("b2b1_result", result, 32'd101);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result(res, lat, bc);
        check("b2b_mul_result", res, 32'd42);
        check("b2b_mul_latency", lat, 33);

        // Reset during a DIVU: nothing from the aborted op may appear
        @(negedge clk);
        alu_op = 1'b1; func3 = 3'd5; func7 = 7'h01; a = 32'd1000; b = 32'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("divu_busy_before_reset", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_result", result, 32'd0);
        stray = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid || busy) stray++;
        end
        check("abort_no_stray_result", stray, 0);
        run_op(1'b0, 3'd0, 7'd0, 32'd2, 32'd2, res, lat, bc);
        check("post_abort_add_result", res, 32'd4);
        check("post_abort_add_latency", lat, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 8..64.
REQ-002 Parameter MUL_EN, default 1, enables RV M-extension decode (1) or base-only decode (0).
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operation request.
REQ-007 in_ready  output  1  unit can accept; transfer on in_valid&&in_ready at clk edge.
REQ-008 func3  input  3  instruction funct3.
REQ-009 func7  input  7  instruction funct7.
REQ-010 alu_op  input  1  1=decode func3/func7 (R/I-type), 0=forced ADD (address calc).
REQ-011 a, b  input  XLEN each  operands (rs1, rs2/imm).
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts; transfer on out_valid&&out_ready.
REQ-014 result  output  XLEN  registered result.
REQ-015 busy  output  1  high while state is CALC.

Function
REQ-016 Operands, func3, func7 and alu_op SHALL be captured on the accept edge; later input changes have no effect on the operation in flight.
REQ-017 alu_op=0 SHALL perform ADD regardless of func3/func7.
REQ-018 alu_op=1, base decode by func3: 000 ADD if func7==0 else SUB; 001 SLL; 010 SLT (signed); 011 SLTU; 100 XOR; 101 SRL if func7==0 else SRA; 110 OR; 111 AND.
REQ-019 Shift amount SHALL be b[log2(XLEN)-1:0]; SLT/SLTU results zero-extended 0/1.
REQ-020 MUL_EN=1 and alu_op=1 and func7==0000001 SHALL select M ops by func3: 000 MUL (low XLEN), 001 MULH (s*s high), 010 MULHSU (s*u high), 011 MULHU (u*u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-021 MUL_EN=0: func7==0000001 SHALL decode per REQ-018 (nonzero func7 -> SUB/SRA).
REQ-022 FSM states IDLE, CALC, DONE; reset state IDLE.
REQ-023 IDLE: accept of base op -> DONE with result loaded, out_valid high on the next cycle (latency 1).
REQ-024 IDLE: accept of M op -> CALC; iterative shift-add/shift-subtract, one bit per cycle, exactly XLEN cycles in CALC, then DONE; out_valid rises XLEN+1 cycles after accept.
REQ-025 CALC: in_ready=0, out_valid=0, busy=1.
REQ-026 DONE: out_valid=1, result stable until out_valid&&out_ready.
REQ-027 in_ready SHALL be 1 in IDLE and in DONE when out_ready=1 (back-to-back); otherwise 0; 0 while rst=1.
REQ-028 DONE with output transfer and simultaneous accept SHALL go directly to DONE (base op) or CALC (M op); without new accept -> IDLE.
REQ-029 Divide by zero: DIV/DIVU quotient all ones; REM/REMU remainder = a; no exception.
REQ-030 Signed overflow (a = most-negative, b = -1): DIV quotient = a, REM = 0.
REQ-031 Signed DIV/REM SHALL round toward zero; remainder sign follows dividend.
REQ-032 All arithmetic modulo 2^XLEN; no flags, no stalls other than CALC.

Reset
REQ-033 rst=1 at a clock edge SHALL force state IDLE, out_valid=0, busy=0, result=0, abort any CALC in progress; no result from the aborted op is ever presented.
REQ-034 First accept possible on the first edge with rst=0.

Verification (XLEN=32, MUL_EN=1)
REQ-035 ADD alu_op=0 a=5 b=7 -> result 0x0000000C, out_valid one cycle after accept.
REQ-036 SUB func3=000 func7=0100000 a=3 b=5 -> 0xFFFFFFFE; SRA a=0x80000000 b=4 -> 0xF8000000; SLTU a=1 b=0xFFFFFFFF -> 1.
REQ-037 MUL a=0xFFFFFFFD b=7 -> 0xFFFFFFEB, out_valid 33 cycles after accept, busy high 32 cycles; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-038 DIV a=17 b=0 -> 0xFFFFFFFF; REM a=17 b=0 -> 17; DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000; REM same -> 0; DIV a=-7 b=2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
REQ-039 out_ready held 0 for 5 cycles in DONE -> result and out_valid stable, in_ready 0; out_ready=1 with in_valid=1 -> next op accepted same edge, back-to-back base ops deliver one result per cycle.
REQ-040 rst pulsed at cycle 10 of a DIVU -> next cycle out_valid=0, busy=0, in_ready=1, result 0; following ADD completes normally.
